// File: rtl/vs_operand_collector_pkg.sv
// Shared shader-core definitions for the vertex-shader operand collector:
// datapath widths, swizzle encodings and the IEEE-754 sign-bit position.
package vs_operand_collector_pkg;

    localparam int SHADER_CORE_DATA_WIDTH = 128;
    localparam int SHADER_COMP_WIDTH      = 32;
    localparam int SHADER_NUM_COMPS       = 4;
    localparam int SHADER_SIGN_BIT        = SHADER_COMP_WIDTH - 1;

    localparam logic [1:0] SWZ_X        = 2'd0;
    localparam logic [1:0] SWZ_Y        = 2'd1;
    localparam logic [1:0] SWZ_Z        = 2'd2;
    localparam logic [1:0] SWZ_W        = 2'd3;
    localparam logic [7:0] SWZ_IDENTITY = 8'hE4;

endpackage

// File: rtl/vs_swizzle_neg.sv
// Combinational swizzle followed by sign flip of every component of one operand.
module vs_swizzle_neg
    import vs_operand_collector_pkg::*;
#(
    parameter int COMP_WIDTH = SHADER_COMP_WIDTH,
    parameter int DATA_WIDTH = SHADER_NUM_COMPS * COMP_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [7:0]            swz_i,
    input  logic                  neg_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    genvar gi;
    generate
        for (gi = 0; gi < SHADER_NUM_COMPS; gi++) begin : g_comp
            logic [1:0]            sel;
            logic [COMP_WIDTH-1:0] comp;

            assign sel  = swz_i[2*gi +: 2];
            assign comp = data_i[int'(sel)*COMP_WIDTH +: COMP_WIDTH];
            // Negate only touches the sign bit; no arithmetic on the magnitude.
            assign data_o[gi*COMP_WIDTH +: COMP_WIDTH] =
                {comp[COMP_WIDTH-1] ^ neg_i, comp[COMP_WIDTH-2:0]};
        end
    endgenerate

endmodule

// File: rtl/vs_operand_collector.sv
// In-order operand collector between the register-file read stage and the
// shader ALU: control is queued at issue, operands are swizzled on return.
module vs_operand_collector
    import vs_operand_collector_pkg::*;
#(
    parameter int DATA_WIDTH = SHADER_CORE_DATA_WIDTH,
    parameter int COMP_WIDTH = SHADER_COMP_WIDTH,
    parameter int DEPTH      = 4,
    parameter int OP_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  iIssueValid,
    input  logic [OP_WIDTH-1:0]   iOpcode,
    input  logic [3:0]            iDstMask,
    input  logic [7:0]            iSrc0Swz,
    input  logic                  iSrc0Neg,
    input  logic [7:0]            iSrc1Swz,
    input  logic                  iSrc1Neg,
    output logic                  oIssueStall,
    input  logic                  iRfValid,
    input  logic [DATA_WIDTH-1:0] iRfSrc0Data,
    input  logic [DATA_WIDTH-1:0] iRfSrc1Data,
    output logic                  oValid,
    input  logic                  iAluReady,
    output logic [OP_WIDTH-1:0]   oOpcode,
    output logic [3:0]            oDstMask,
    output logic [DATA_WIDTH-1:0] oSrc0,
    output logic [DATA_WIDTH-1:0] oSrc1,
    output logic                  oErr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] alloc_q, alloc_d;
    logic [PTR_W-1:0] fill_q, fill_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             err_q, err_d;

    logic issue_acc, fill_acc, deq;

    logic [OP_WIDTH-1:0]   op_arr    [DEPTH];
    logic [3:0]            mask_arr  [DEPTH];
    logic [7:0]            swz0_arr  [DEPTH];
    logic [7:0]            swz1_arr  [DEPTH];
    logic                  neg0_arr  [DEPTH];
    logic                  neg1_arr  [DEPTH];
    logic [DATA_WIDTH-1:0] src0_arr  [DEPTH];
    logic [DATA_WIDTH-1:0] src1_arr  [DEPTH];
    logic [DEPTH-1:0]      filled_vec;

    logic [DATA_WIDTH-1:0] src0_proc, src1_proc;

    assign oIssueStall = (count_q == CNT_W'(DEPTH));
    assign issue_acc   = iIssueValid && !oIssueStall;
    // pending counts allocated-but-unfilled entries, so a return with none is spurious.
    assign fill_acc    = iRfValid && (pending_q != '0);
    assign oValid      = (count_q != '0) && filled_vec[head_q];
    assign deq         = oValid && iAluReady;

    assign oOpcode  = op_arr[head_q];
    assign oDstMask = mask_arr[head_q];
    assign oSrc0    = src0_arr[head_q];
    assign oSrc1    = src1_arr[head_q];
    assign oErr     = err_q;

    // The swizzle controls come from the entry being filled, not from the issue port.
    vs_swizzle_neg #(
        .COMP_WIDTH (COMP_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_swz_src0 (
        .data_i (iRfSrc0Data),
        .swz_i  (swz0_arr[fill_q]),
        .neg_i  (neg0_arr[fill_q]),
        .data_o (src0_proc)
    );

    vs_swizzle_neg #(
        .COMP_WIDTH (COMP_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_swz_src1 (
        .data_i (iRfSrc1Data),
        .swz_i  (swz1_arr[fill_q]),
        .neg_i  (neg1_arr[fill_q]),
        .data_o (src1_proc)
    );

    always_comb begin
        alloc_d   = alloc_q + PTR_W'(issue_acc);
        fill_d    = fill_q + PTR_W'(fill_acc);
        head_d    = head_q + PTR_W'(deq);
        count_d   = count_q + CNT_W'(issue_acc) - CNT_W'(deq);
        pending_d = pending_q + CNT_W'(issue_acc) - CNT_W'(fill_acc);
        err_d     = err_q
                  | (iIssueValid && oIssueStall)
                  | (iRfValid && !fill_acc);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            alloc_q   <= '0;
            fill_q    <= '0;
            head_q    <= '0;
            count_q   <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            alloc_q   <= alloc_d;
            fill_q    <= fill_d;
            head_q    <= head_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [OP_WIDTH-1:0]   op_q;
            logic [3:0]            mask_q;
            logic [7:0]            swz0_q, swz1_q;
            logic                  neg0_q, neg1_q;
            logic [DATA_WIDTH-1:0] src0_q, src1_q;
            logic                  filled_q;
            logic                  is_alloc, is_fill, is_head;

            assign is_alloc = issue_acc && (alloc_q == PTR_W'(gi));
            assign is_fill  = fill_acc && (fill_q == PTR_W'(gi));
            assign is_head  = deq && (head_q == PTR_W'(gi));

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    op_q     <= '0;
                    mask_q   <= '0;
                    swz0_q   <= '0;
                    swz1_q   <= '0;
                    neg0_q   <= 1'b0;
                    neg1_q   <= 1'b0;
                    src0_q   <= '0;
                    src1_q   <= '0;
                    filled_q <= 1'b0;
                end else begin
                    if (is_alloc) begin
                        op_q     <= iOpcode;
                        mask_q   <= iDstMask;
                        swz0_q   <= iSrc0Swz;
                        swz1_q   <= iSrc1Swz;
                        neg0_q   <= iSrc0Neg;
                        neg1_q   <= iSrc1Neg;
                        filled_q <= 1'b0;
                    end
                    if (is_fill) begin
                        src0_q   <= src0_proc;
                        src1_q   <= src1_proc;
                        filled_q <= 1'b1;
                    end
                    if (is_head) begin
                        filled_q <= 1'b0;
                    end
                end
            end

            assign op_arr[gi]     = op_q;
            assign mask_arr[gi]   = mask_q;
            assign swz0_arr[gi]   = swz0_q;
            assign swz1_arr[gi]   = swz1_q;
            assign neg0_arr[gi]   = neg0_q;
            assign neg1_arr[gi]   = neg1_q;
            assign src0_arr[gi]   = src0_q;
            assign src1_arr[gi]   = src1_q;
            assign filled_vec[gi] = filled_q;
        end
    endgenerate

endmodule
